// File: rtl/uart_rx_cmd_parser_if.sv
// Bundles the parser's byte-stream, register-file, transmit and status signals.
// master = parser side, slave = receiver/register-file/transmitter side.
interface uart_rx_cmd_parser_if #(
    parameter int W      = 8,
    parameter int ADDR_W = 4
);
    logic [W-1:0]      rx_data;
    logic              rx_valid;
    logic              rx_par_err;
    logic              rx_stp_err;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [W-1:0]      wr_data;
    logic [W-1:0]      rd_data;
    logic              rd_data_valid;
    logic [W-1:0]      tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              cmd_err;
    logic              rx_overrun;
    logic              busy;

    modport master (
        input  rx_data, rx_valid, rx_par_err, rx_stp_err, rd_data, rd_data_valid, tx_ready,
        output wr_en, rd_en, addr, wr_data, tx_data, tx_valid, cmd_err, rx_overrun, busy
    );

    modport slave (
        output rx_data, rx_valid, rx_par_err, rx_stp_err, rd_data, rd_data_valid, tx_ready,
        input  wr_en, rd_en, addr, wr_data, tx_data, tx_valid, cmd_err, rx_overrun, busy
    );
endinterface

// File: rtl/uart_rx_cmd_parser.sv
// Decodes UART command frames (AA addr data / BB addr) into register writes/reads and
// returns read data over a valid/ready handshake; all outputs are registered.
module uart_rx_cmd_parser #(
    parameter int W       = 8,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_rx_cmd_parser_if.master  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [W-1:0]  CMD_WR = W'(8'hAA);
    localparam logic [W-1:0]  CMD_RD = W'(8'hBB);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_ADDR = 3'd1;
    localparam logic [2:0] WR_DATA = 3'd2;
    localparam logic [2:0] WR_EXEC = 3'd3;
    localparam logic [2:0] RD_ADDR = 3'd4;
    localparam logic [2:0] RD_EXEC = 3'd5;
    localparam logic [2:0] RD_WAIT = 3'd6;
    localparam logic [2:0] TX_SEND = 3'd7;

    logic [2:0]    state, state_nxt;
    logic [TW-1:0] timer;
    logic          err_nxt, ovr_nxt, ld_addr, ld_wr, ld_tx;
    logic          rx_err, tmo, waiting, addr_bad;

    assign rx_err   = bus.rx_par_err | bus.rx_stp_err;
    assign tmo      = (timer == T_LAST);
    assign addr_bad = (bus.rx_data[W-1:ADDR_W] != '0);
    assign waiting  = (state == WR_ADDR) || (state == WR_DATA) ||
                      (state == RD_ADDR) || (state == RD_WAIT);

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        ovr_nxt   = 1'b0;
        ld_addr   = 1'b0;
        ld_wr     = 1'b0;
        ld_tx     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rx_valid && !rx_err) begin
                    if (bus.rx_data == CMD_WR)      state_nxt = WR_ADDR;
                    else if (bus.rx_data == CMD_RD) state_nxt = RD_ADDR;
                    else                            err_nxt   = 1'b1;
                end
            end
            WR_ADDR, RD_ADDR: begin
                // A receiver error discards any byte arriving in the same cycle
                if (rx_err) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else if (bus.rx_valid) begin
                    if (addr_bad) begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end else begin
                        ld_addr   = 1'b1;
                        state_nxt = (state == WR_ADDR) ? WR_DATA : RD_EXEC;
                    end
                end else if (tmo) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            WR_DATA: begin
                if (rx_err) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else if (bus.rx_valid) begin
                    ld_wr     = 1'b1;
                    state_nxt = WR_EXEC;
                end else if (tmo) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            WR_EXEC: begin
                ovr_nxt   = bus.rx_valid;
                state_nxt = IDLE;
            end
            RD_EXEC: begin
                ovr_nxt   = bus.rx_valid;
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (rx_err) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    ovr_nxt = bus.rx_valid;
                    if (bus.rd_data_valid) begin
                        ld_tx     = 1'b1;
                        state_nxt = TX_SEND;
                    end else if (tmo) begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                end
            end
            TX_SEND: begin
                ovr_nxt = bus.rx_valid;
                if (bus.tx_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            timer          <= '0;
            bus.wr_en      <= 1'b0;
            bus.rd_en      <= 1'b0;
            bus.addr       <= '0;
            bus.wr_data    <= '0;
            bus.tx_data    <= '0;
            bus.tx_valid   <= 1'b0;
            bus.cmd_err    <= 1'b0;
            bus.rx_overrun <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            state <= state_nxt;
            // Any state change re-arms the timer for the next waiting state
            if (state_nxt != state) timer <= '0;
            else if (waiting)       timer <= timer + TW'(1);
            if (ld_addr) bus.addr    <= bus.rx_data[ADDR_W-1:0];
            if (ld_wr)   bus.wr_data <= bus.rx_data;
            if (ld_tx)   bus.tx_data <= bus.rd_data;
            bus.wr_en      <= (state_nxt == WR_EXEC);
            bus.rd_en      <= (state_nxt == RD_EXEC);
            bus.tx_valid   <= (state_nxt == TX_SEND);
            bus.busy       <= (state_nxt != IDLE);
            bus.cmd_err    <= err_nxt;
            bus.rx_overrun <= ovr_nxt;
        end
    end
endmodule
